// File: rtl/cpu_memory.sv
// 64x8 CPU bus responder RAM with a byte-stream program loader that holds the CPU in reset.
// Optional MMIO output latch at the all-ones address is enabled by defining MMIO_OUT_EN.
module cpu_memory #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int RELEASE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_reset,
  output logic [DATA_W-1:0] io_out,
  output logic              io_strobe
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (RELEASE_CYC < 1) ? 1 : $clog2(RELEASE_CYC + 1);

  typedef enum logic [1:0] {RUN, LOAD, RELEASE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0]  rel_cnt_reg, rel_cnt_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              cpu_reset_reg;
  logic              load_ready_reg;

  logic load_accept;
  logic load_end;
  logic cpu_we;

  // load_ready mirrors the LOAD state, so acceptance only needs the state.
  assign load_accept = (state_reg == LOAD) && load_valid;
  assign load_end    = load_accept && (load_last || (ptr_reg == '1));
  assign cpu_we      = (state_reg == RUN) && !rw;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    rel_cnt_next = rel_cnt_reg;
    case (state_reg)
      RUN: begin
        if (load_valid) begin
          state_next = LOAD;
          ptr_next   = '0;
        end
      end
      LOAD: begin
        if (load_accept) begin
          ptr_next = ptr_reg + 1'b1;
        end
        if (load_end) begin
          state_next   = RELEASE;
          ptr_next     = '0;
          rel_cnt_next = CNT_W'(RELEASE_CYC);
        end
      end
      RELEASE: begin
        rel_cnt_next = rel_cnt_reg - 1'b1;
        if (rel_cnt_reg <= CNT_W'(1)) begin
          state_next = RUN;
        end
      end
      default: state_next = RELEASE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RELEASE;
      ptr_reg        <= '0;
      rel_cnt_reg    <= CNT_W'(RELEASE_CYC);
      cpu_reset_reg  <= 1'b1;
      load_ready_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      rel_cnt_reg    <= rel_cnt_next;
      cpu_reset_reg  <= (state_next != RUN);
      load_ready_reg <= (state_next == LOAD);
    end
  end

  // Single write port shared by loader and CPU; the two never write in the same state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load_accept) begin
        mem[ptr_reg] <= load_data;
      end else if (cpu_we) begin
        mem[addr] <= wr_data;
      end
    end
  end

  // Registered read returns pre-write data on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[addr];
    end
  end

  assign rd_data    = rd_data_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign load_ready = load_ready_reg;

`ifdef MMIO_OUT_EN
  logic              rw_q_reg;
  logic [DATA_W-1:0] io_out_reg;
  logic              io_strobe_reg;
  logic              mmio_hit;

  assign mmio_hit = cpu_we && (addr == '1);

  // Strobe only on the first write cycle of the two-cycle CPU access.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q_reg      <= 1'b1;
      io_out_reg    <= '0;
      io_strobe_reg <= 1'b0;
    end else begin
      rw_q_reg      <= rw;
      io_strobe_reg <= mmio_hit && rw_q_reg;
      if (mmio_hit) begin
        io_out_reg <= wr_data;
      end
    end
  end

  assign io_out    = io_out_reg;
  assign io_strobe = io_strobe_reg;
`else
  assign io_out    = '0;
  assign io_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_memory.sv
// Directed self-checking bench for cpu_memory: loader, CPU read/write, auto-wrap, MMIO, reset mid-load.
module tb_cpu_memory;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] addr;
  logic       rw;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       cpu_reset;
  logic [7:0] io_out;
  logic       io_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_memory #(.ADDR_W(6), .DATA_W(8), .RELEASE_CYC(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .rw        (rw),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .cpu_reset (cpu_reset),
    .io_out    (io_out),
    .io_strobe (io_strobe)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_cmp++;
    if (rd_data !== 8'h00 || load_ready !== 1'b0 || cpu_reset !== 1'b1 ||
        io_out !== 8'h00 || io_strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: rd=%h rdy=%b crst=%b io=%h stb=%b, want 00 0 1 00 0",
               rd_data, load_ready, cpu_reset, io_out, io_strobe);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hold: cpu_reset=%b want 1", cpu_reset);
    end
    step();
    n_cmp++;
    if (cpu_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: cpu_reset=%b want 0", cpu_reset);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_basic();
    logic [7:0] bytes [3];
    bytes[0] = 8'h41; bytes[1] = 8'h90; bytes[2] = 8'hC0;
    load_valid = 1'b1;
    load_data  = bytes[0];
    step();
    n_cmp++;
    if (load_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL load_enter: rdy=%b crst=%b want 1 1", load_ready, cpu_reset);
    end
    for (int i = 0; i < 3; i++) begin
      load_data = bytes[i];
      load_last = (i == 2);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL load_end: rdy=%b crst=%b want 0 1", load_ready, cpu_reset);
    end
    step();
    n_cmp++;
    if (cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL load_release_hold: cpu_reset=%b want 1", cpu_reset);
    end
    step();
    n_cmp++;
    if (cpu_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL load_release: cpu_reset=%b want 0", cpu_reset);
    end
    rw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 6'(i);
      step();
      n_cmp++;
      if (rd_data !== bytes[i]) begin
        n_bad++;
        $display("FAIL load_mem[%0d]: got %h want %h", i, rd_data, bytes[i]);
      end
    end
    $display("test_load_basic done");
  endtask

  task automatic test_read();
    addr = 6'd5; rw = 1'b0; wr_data = 8'hA5;
    step();
    step();
    rw = 1'b1; wr_data = 8'h11;
    step();
    n_cmp++;
    if (rd_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL read_5: got %h want a5", rd_data);
    end
    step();
    step();
    n_cmp++;
    if (rd_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL read_no_write: got %h want a5", rd_data);
    end
    $display("test_read done");
  endtask

  task automatic test_write();
    addr = 6'h10; rw = 1'b0; wr_data = 8'h33;
    step();
    step();
    rw = 1'b1;
    step();
    wr_data = 8'h5C; rw = 1'b0;
    step();
    n_cmp++;
    if (rd_data !== 8'h33) begin
      n_bad++;
      $display("FAIL write_old_data: got %h want 33", rd_data);
    end
    step();
    rw = 1'b1;
    step();
    n_cmp++;
    if (rd_data !== 8'h5C) begin
      n_bad++;
      $display("FAIL write_new_data: got %h want 5c", rd_data);
    end
    $display("test_write done");
  endtask

  task automatic test_autowrap();
    load_valid = 1'b1;
    load_data  = 8'hFF;
    step();
    for (int i = 0; i < 64; i++) begin
      load_data = 8'(i) ^ 8'hFF;
      step();
    end
    // 65th byte stays offered throughout RELEASE
    load_data = 8'hAB;
    n_cmp++;
    if (load_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_end: rdy=%b crst=%b want 0 1", load_ready, cpu_reset);
    end
    step();
    step();
    n_cmp++;
    if (load_ready !== 1'b0 || cpu_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_run: rdy=%b crst=%b want 0 0", load_ready, cpu_reset);
    end
    step();
    n_cmp++;
    if (load_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_reload: rdy=%b crst=%b want 1 1", load_ready, cpu_reset);
    end
    load_last = 1'b1;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    step();
    step();
    rw = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] exp;
      exp = (i == 0) ? 8'hAB : (8'(i) ^ 8'hFF);
      addr = 6'(i);
      step();
      n_cmp++;
      if (rd_data !== exp) begin
        n_bad++;
        $display("FAIL wrap_mem[%0d]: got %h want %h", i, rd_data, exp);
      end
    end
    $display("test_autowrap done");
  endtask

  task automatic test_mmio();
    logic [7:0] exp_io;
    logic       exp_stb;
`ifdef MMIO_OUT_EN
    exp_io = 8'h77; exp_stb = 1'b1;
`else
    exp_io = 8'h00; exp_stb = 1'b0;
`endif
    addr = 6'h3F; rw = 1'b0; wr_data = 8'h77;
    step();
    n_cmp++;
    if (io_out !== exp_io || io_strobe !== exp_stb) begin
      n_bad++;
      $display("FAIL mmio_first: io=%h stb=%b want %h %b", io_out, io_strobe, exp_io, exp_stb);
    end
    step();
    n_cmp++;
    if (io_out !== exp_io || io_strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL mmio_second: io=%h stb=%b want %h 0", io_out, io_strobe, exp_io);
    end
    rw = 1'b1;
    step();
    n_cmp++;
    if (io_out !== exp_io || io_strobe !== 1'b0 || rd_data !== 8'h77) begin
      n_bad++;
      $display("FAIL mmio_after: io=%h stb=%b rd=%h want %h 0 77", io_out, io_strobe, rd_data, exp_io);
    end
    $display("test_mmio done");
  endtask

  task automatic test_reset_mid_load();
    load_valid = 1'b1;
    load_data  = 8'h80;
    step();
    for (int i = 0; i < 10; i++) begin
      load_data = 8'h80 + 8'(i);
      step();
    end
    load_data = 8'h8A;
    reset = 1'b1;
    step();
    n_cmp++;
    if (load_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL midload_reset: rdy=%b crst=%b want 0 1", load_ready, cpu_reset);
    end
    reset = 1'b0;
    load_valid = 1'b0;
    step();
    n_cmp++;
    if (cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL midload_hold: cpu_reset=%b want 1", cpu_reset);
    end
    step();
    n_cmp++;
    if (cpu_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL midload_release: cpu_reset=%b want 0", cpu_reset);
    end
    rw = 1'b1;
    for (int i = 0; i < 11; i++) begin
      logic [7:0] exp;
      exp = (i < 10) ? (8'h80 + 8'(i)) : 8'hF5;
      addr = 6'(i);
      step();
      n_cmp++;
      if (rd_data !== exp) begin
        n_bad++;
        $display("FAIL midload_mem[%0d]: got %h want %h", i, rd_data, exp);
      end
    end
    $display("test_reset_mid_load done");
  endtask

  initial begin
    reset = 1'b1; addr = '0; rw = 1'b1; wr_data = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    #1;
    test_reset();
    test_load_basic();
    test_read();
    test_write();
    test_autowrap();
    test_mmio();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
